// File: rtl/ram_sdp_bwe_clr.sv
`timescale 1ns/1ps
// Simple-dual-port RAM with per-lane write enables, 1- or 2-cycle read latency and a clear sequencer.
// Defining RAM_SDP_WR_BYPASS_EN makes same-address read/write return the freshly written lanes.
module ram_sdp_bwe_clr #(
  parameter int                 ADDR_W  = 9,
  parameter int                 DEPTH   = 512,
  parameter int                 DATA_W  = 32,
  parameter int                 LANE_W  = 8,
  parameter int                 REG_RD  = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [ADDR_W-1:0]          WA,
  input  logic [DATA_W-1:0]          WD,
  input  logic [DATA_W/LANE_W-1:0]   WEN,
  input  logic                       WClk_En,
  input  logic [ADDR_W-1:0]          RA,
  input  logic                       RClk_En,
  output logic [DATA_W-1:0]          RD,
  output logic                       RD_Vld,
  input  logic                       Clr,
  output logic                       Busy
);

  localparam int                NLANE    = DATA_W / LANE_W;
  localparam int                MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_ok_s;
  logic                rd_req_s;
  logic                rd_in_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [DATA_W-1:0]   rd1_q;
  logic                rd1_vld_q;

  assign wr_ok_s  = (state_q == ST_IDLE) && WClk_En && ({1'b0, WA} < DEPTH_C);
  assign rd_req_s = (state_q == ST_IDLE) && RClk_En;
  assign rd_in_s  = ({1'b0, RA} < DEPTH_C);

  // Clear sequencer; Busy is registered alongside the state so it tracks CLEAR exactly.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (Clr) begin
            cnt_q  <= '0;
            busy_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + ADDR_W'(1);
            busy_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (Clr) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: the clear sequencer owns the write port while clearing.
  always_ff @(posedge Clk) begin
    if (state_q == ST_CLEAR) begin
      mem[cnt_q[MEM_AW-1:0]] <= CLR_VAL;
    end else if (wr_ok_s) begin
      for (int i = 0; i < NLANE; i++) begin
        if (WEN[i]) begin
          mem[WA[MEM_AW-1:0]][i*LANE_W +: LANE_W] <= WD[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Read word selection; out-of-range addresses read as zero.
  always_comb begin
    rd_word_s = '0;
    if (rd_in_s) begin
      rd_word_s = mem[RA[MEM_AW-1:0]];
    end else begin
      rd_word_s = '0;
    end
`ifdef RAM_SDP_WR_BYPASS_EN
    if (wr_ok_s && (WA == RA)) begin
      for (int i = 0; i < NLANE; i++) begin
        if (WEN[i]) begin
          rd_word_s[i*LANE_W +: LANE_W] = WD[i*LANE_W +: LANE_W];
        end else begin
          rd_word_s[i*LANE_W +: LANE_W] = rd_word_s[i*LANE_W +: LANE_W];
        end
      end
    end else begin
      rd_word_s = rd_word_s;
    end
`endif
  end

  // First read stage; data holds when no read is accepted.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd1_q     <= '0;
      rd1_vld_q <= 1'b0;
    end else begin
      rd1_vld_q <= rd_req_s;
      if (rd_req_s) begin
        rd1_q <= rd_word_s;
      end
    end
  end

  generate
    if (REG_RD != 0) begin : g_reg_rd
      logic [DATA_W-1:0] rd2_q;
      logic              rd2_vld_q;

      // Optional output register; never gated by Busy so in-flight reads complete.
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          rd2_q     <= '0;
          rd2_vld_q <= 1'b0;
        end else begin
          rd2_vld_q <= rd1_vld_q;
          if (rd1_vld_q) begin
            rd2_q <= rd1_q;
          end
        end
      end

      assign RD     = rd2_q;
      assign RD_Vld = rd2_vld_q;
    end else begin : g_comb_rd
      assign RD     = rd1_q;
      assign RD_Vld = rd1_vld_q;
    end
  endgenerate

  assign Busy = busy_q;

endmodule

// File: tb/tb_ram_sdp_bwe_clr.sv
`timescale 1ns/1ps
// Scoreboard bench: two RAM instances (latency 1 and 2) share stimulus and are checked against a word-array model.
module tb_ram_sdp_bwe_clr;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 512;
  localparam int          DATA_W = 32;
  localparam int          LANE_W = 8;
  localparam int          NLANE  = 4;
  localparam logic [31:0] CLR_V  = 32'hDEADBEEF;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic [ADDR_W-1:0] WA = '0;
  logic [DATA_W-1:0] WD = '0;
  logic [NLANE-1:0]  WEN = '0;
  logic              WClk_En = 1'b0;
  logic [ADDR_W-1:0] RA = '0;
  logic              RClk_En = 1'b0;
  logic              Clr = 1'b0;
  logic [DATA_W-1:0] rd0, rd1;
  logic              vld0, vld1, busy0, busy1;

  ram_sdp_bwe_clr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .LANE_W(LANE_W),
                    .REG_RD(0), .CLR_VAL(CLR_V)) u_dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .WA(WA), .WD(WD), .WEN(WEN), .WClk_En(WClk_En),
    .RA(RA), .RClk_En(RClk_En), .RD(rd0), .RD_Vld(vld0), .Clr(Clr), .Busy(busy0));

  ram_sdp_bwe_clr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .LANE_W(LANE_W),
                    .REG_RD(1), .CLR_VAL(CLR_V)) u_dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .WA(WA), .WD(WD), .WEN(WEN), .WClk_En(WClk_En),
    .RA(RA), .RClk_En(RClk_En), .RD(rd1), .RD_Vld(vld1), .Clr(Clr), .Busy(busy1));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model_mem [DEPTH];
  int          busy_left = DEPTH;
  logic        exp_busy = 1'b1;
  int          edge_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < NLANE; i++) begin
      if (wen[i]) r[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  // Reference behaviour for the coming clock edge, from the current inputs.
  task automatic model_step();
    logic [31:0] e;
    int          due;
    due = edge_cnt + 1;
    if (busy_left == 0) begin
      if (RClk_En) begin
        e = (int'(RA) < DEPTH) ? model_mem[RA] : 32'h0;
`ifdef RAM_SDP_WR_BYPASS_EN
        if (WClk_En && (WA == RA) && (int'(WA) < DEPTH)) e = merge(e, WD, WEN);
`endif
        q0.push_back('{e, due});
        q1.push_back('{e, due + 1});
      end
      if (WClk_En && (int'(WA) < DEPTH)) model_mem[WA] = merge(model_mem[WA], WD, WEN);
      if (Clr) begin
        busy_left = DEPTH;
        for (int a = 0; a < DEPTH; a++) model_mem[a] = CLR_V;
      end
    end else if (Clr) begin
      busy_left = DEPTH;
    end else begin
      busy_left--;
    end
    exp_busy = (busy_left > 0);
  endtask

  task automatic apply(input logic we, input int wa, input logic [31:0] wd, input logic [3:0] wen,
                       input logic re, input int ra, input logic clr);
    WClk_En = we; WA = ADDR_W'(wa); WD = wd; WEN = wen;
    RClk_En = re; RA = ADDR_W'(ra); Clr = clr;
    model_step();
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 0, 32'h0, 4'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic random_op(input logic clr_en);
    int wa;
    int ra;
    wa = $urandom_range(0, 599);
    ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 599);
    apply(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), ra, clr_en && ($urandom_range(0, 399) == 0));
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_vld0", 32'(vld0), 32'h0);
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_vld1", 32'(vld1), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h1);
    q0.delete();
    q1.delete();
    busy_left = DEPTH;
    exp_busy  = 1'b1;
    last0 = '0;
    last1 = '0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = CLR_V;
    WClk_En = 1'b0; RClk_En = 1'b0; Clr = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a port presents RD_Vld.
  always @(posedge Clk) begin
    #1;
    if (Rst_n) begin
      chk("busy0", 32'(busy0), 32'(exp_busy));
      chk("busy1", 32'(busy1), 32'(exp_busy));
      if (vld0) begin
        if (q0.size() == 0) chk("unexpected_vld0", 32'(vld0), 32'h0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("rd0_due", 32'(edge_cnt), 32'(e.due));
          chk("rd0_data", rd0, e.data);
          last0 = e.data;
        end
      end else begin
        chk("rd0_hold", rd0, last0);
        if (q0.size() != 0 && q0[0].due <= edge_cnt) chk("rd0_vld", 32'(vld0), 32'h1);
      end
      if (vld1) begin
        if (q1.size() == 0) chk("unexpected_vld1", 32'(vld1), 32'h0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("rd1_due", 32'(edge_cnt), 32'(e.due));
          chk("rd1_data", rd1, e.data);
          last1 = e.data;
        end
      end else begin
        chk("rd1_hold", rd1, last1);
        if (q1.size() != 0 && q1[0].due <= edge_cnt) chk("rd1_vld", 32'(vld1), 32'h1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge Clk);
    do_reset();
    // Attempted traffic during the power-up clear, then reset at cnt=100.
    for (int i = 0; i < 100; i++) random_op(1'b0);
    do_reset();
    for (int i = 0; i < 520; i++) random_op(1'b0);
    idle(2);

    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 0, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 255, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 511, 1'b0);
    idle(2);

    apply(1'b1, 5, 32'h11223344, 4'b1111, 1'b0, 0, 1'b0);
    apply(1'b1, 5, 32'hAABBCCDD, 4'b0101, 1'b0, 0, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 5, 1'b0);
    apply(1'b1, 7, 32'hFFFF0000, 4'hF, 1'b1, 7, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 7, 1'b0);
    idle(2);

    for (int a = 0; a < DEPTH; a++) apply(1'b1, a, 32'(a), 4'hF, 1'b0, 0, 1'b0);
    apply(1'b1, 3, 32'h12345678, 4'hF, 1'b1, 3, 1'b1);
    for (int i = 0; i < 520; i++) random_op(1'b0);
    for (int a = 0; a < DEPTH; a++) apply(1'b0, 0, 32'h0, 4'h0, 1'b1, a, 1'b0);
    idle(2);

    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 600, 1'b0);
    apply(1'b1, 600, 32'hCAFEF00D, 4'hF, 1'b0, 0, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 88, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 600, 1'b0);
    idle(2);

    for (int i = 0; i < 2000; i++) random_op(1'b1);

    for (int i = 0; i < 2000 && busy_left > 0; i++) idle(1);
    apply(1'b1, 9, 32'h5A5AA5A5, 4'hF, 1'b0, 0, 1'b0);
    apply(1'b0, 0, 32'h0, 4'h0, 1'b1, 9, 1'b0);
    do_reset();
    for (int i = 0; i < 520; i++) random_op(1'b0);
    idle(4);
    chk("q_empty", 32'(q0.size() + q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
